// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer and status controller for the async FIFO.
// All state lives in the write clock domain.
module fifo_wr_ctrl #(
  parameter int ADDR_WIDTH   = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  winc,
  input  logic                  wclr_ovf,
  input  logic [ADDR_WIDTH:0]   wq2_rptr,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  woverflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AF = PW'(AFULL_THRESH);

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] rbin;
  logic [PW-1:0] rptr_full;
  logic [PW-1:0] wlevel_next;
  logic          push;

  always_comb begin
    push      = winc & ~wfull;
    wbin_next = wbin + {{ADDR_WIDTH{1'b0}}, push};
    gray_next = wbin_next ^ (wbin_next >> 1);
  end

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin = '0;
    for (int i = 0; i < PW; i++) begin
      rbin[i] = ^(wq2_rptr >> i);
    end
  end

  always_comb begin
    rptr_full   = {~wq2_rptr[PW-1:PW-2], wq2_rptr[PW-3:0]};
    wlevel_next = wbin_next - rbin;
  end

  assign waddr = wbin[ADDR_WIDTH-1:0];

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      wbin         <= '0;
      wptr_gray    <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
      woverflow    <= 1'b0;
    end else begin
      wbin         <= wbin_next;
      wptr_gray    <= gray_next;
      wfull        <= (gray_next == rptr_full);
      walmost_full <= (wlevel_next >= AF);
      wlevel       <= wlevel_next;
      // A rejected write outranks a clear in the same cycle.
      if (winc & wfull) begin
        woverflow <= 1'b1;
      end else if (wclr_ovf) begin
        woverflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl with an occupancy-count model.
// Outputs are compared against the model on every falling edge.
module tb_fifo_wr_ctrl;

  localparam int AW    = 3;
  localparam int AFT   = 6;
  localparam int DEPTH = 1 << AW;
  localparam int PTRS  = 1 << (AW + 1);

  logic          wclk = 1'b0;
  logic          wrst_n;
  logic          winc;
  logic          wclr_ovf;
  logic [AW:0]   wq2_rptr;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr_gray;
  logic          wfull;
  logic          walmost_full;
  logic [AW:0]   wlevel;
  logic          woverflow;

  int n_vec  = 0;
  int n_fail = 0;
  int rd_bin = 0;
  bit chk_en = 1'b0;

  int m_wr   = 0;
  int m_lvl  = 0;
  bit m_full = 1'b0;
  bit m_af   = 1'b0;
  bit m_ovf  = 1'b0;

  fifo_wr_ctrl #(.ADDR_WIDTH(AW), .AFULL_THRESH(AFT)) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .winc         (winc),
    .wclr_ovf     (wclr_ovf),
    .wq2_rptr     (wq2_rptr),
    .waddr        (waddr),
    .wptr_gray    (wptr_gray),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .woverflow    (woverflow)
  );

  always #5 wclk = ~wclk;

  assign wq2_rptr = (AW+1)'(rd_bin ^ (rd_bin >> 1));

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp,
               $time);
    end
  endtask

  // Model: occupancy is writes minus reads, modulo the pointer range.
  always @(posedge wclk) begin : model
    int nw;
    int lv;
    if (!wrst_n) begin
      m_wr   <= 0;
      m_lvl  <= 0;
      m_full <= 1'b0;
      m_af   <= 1'b0;
      m_ovf  <= 1'b0;
    end else begin
      nw = (m_wr + ((winc && !m_full) ? 1 : 0)) % PTRS;
      lv = (nw - rd_bin + PTRS) % PTRS;
      m_wr   <= nw;
      m_lvl  <= lv;
      m_full <= (lv == DEPTH);
      m_af   <= (lv >= AFT);
      if (winc && m_full) m_ovf <= 1'b1;
      else if (wclr_ovf) m_ovf <= 1'b0;
    end
  end

  always @(negedge wclk) begin
    if (chk_en) begin
      chk("waddr", 32'(waddr), 32'(m_wr % DEPTH));
      chk("wptr_gray", 32'(wptr_gray), 32'(m_wr ^ (m_wr >> 1)));
      chk("wfull", 32'(wfull), 32'(m_full));
      chk("walmost_full", 32'(walmost_full), 32'(m_af));
      chk("wlevel", 32'(wlevel), 32'(m_lvl));
      chk("woverflow", 32'(woverflow), 32'(m_ovf));
    end
  end

  task automatic step(input logic inc, input logic clr);
    winc     = inc;
    wclr_ovf = clr;
    @(posedge wclk);
    @(negedge wclk);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_waddr"}, 32'(waddr), 0);
    chk({nm, "_gray"}, 32'(wptr_gray), 0);
    chk({nm, "_full"}, 32'(wfull), 0);
    chk({nm, "_afull"}, 32'(walmost_full), 0);
    chk({nm, "_level"}, 32'(wlevel), 0);
    chk({nm, "_ovf"}, 32'(woverflow), 0);
  endtask

  initial begin
    logic [AW:0] prev;
    int wb;

    wrst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rd_bin = $urandom_range(0, PTRS - 1);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk_en = 1'b1;
    end
    chk_zero("rst");
    rd_bin = 0;
    wrst_n = 1'b1;
    step(1'b0, 1'b0);
    chk_zero("rel");

    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0);
      if (i == 5) chk("af_5th", 32'(walmost_full), 0);
      if (i == 6) chk("af_6th", 32'(walmost_full), 1);
    end
    chk("fill_full", 32'(wfull), 1);
    chk("fill_level", 32'(wlevel), 8);
    chk("fill_waddr", 32'(waddr), 0);
    chk("fill_gray", 32'(wptr_gray), 32'b1100);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    chk("ovf_gray", 32'(wptr_gray), 32'b1100);
    chk("ovf_set", 32'(woverflow), 1);
    step(1'b1, 1'b1);
    chk("ovf_setwins", 32'(woverflow), 1);
    step(1'b0, 1'b1);
    chk("ovf_clr", 32'(woverflow), 0);

    rd_bin = 1;
    step(1'b0, 1'b0);
    chk("drain_full", 32'(wfull), 0);
    chk("drain_level7", 32'(wlevel), 7);
    chk("drain_af", 32'(walmost_full), 1);
    rd_bin = 2;
    step(1'b0, 1'b0);
    chk("drain_level6", 32'(wlevel), 6);

    rd_bin = 3;
    step(1'b1, 1'b0);
    chk("simul_level", 32'(wlevel), 6);
    chk("simul_waddr", 32'(waddr), 1);

    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("refill_full", 32'(wfull), 1);
    step(1'b1, 1'b0);
    chk("refill_ovf", 32'(woverflow), 1);

    wrst_n = 1'b0;
    rd_bin = 0;
    step(1'b1, 1'b1);
    chk_zero("midrst");
    wrst_n = 1'b1;
    step(1'b1, 1'b0);
    chk("post_waddr", 32'(waddr), 1);
    chk("post_gray", 32'(wptr_gray), 32'b0001);

    wb = 1;
    for (int i = 0; i < 20; i++) begin
      prev   = wptr_gray;
      rd_bin = (wb - 2 + PTRS) % PTRS;
      step(1'b1, 1'b0);
      wb = (wb + 1) % PTRS;
      chk("wrap_nofull", 32'(wfull), 0);
      chk("wrap_onebit", 32'($countones(wptr_gray ^ prev)), 1);
      if (wb == 8) chk("wrap_g8", 32'(wptr_gray), 32'b1100);
      if (wb == 15) chk("wrap_g15", 32'(wptr_gray), 32'b1000);
      if (wb == 0) chk("wrap_g0", 32'(wptr_gray), 32'b0000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
